// File: rtl/seg7_pkg.sv
// Shared types, segment patterns, digit positions and BCD decode for the
// seven-segment scan driver.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Display positions: left group on 7..5, unused gap on 4..3, right group on 2..0
  localparam logic [2:0] DIG_L_HUN  = 3'd7;
  localparam logic [2:0] DIG_L_TEN  = 3'd6;
  localparam logic [2:0] DIG_L_ONE  = 3'd5;
  localparam logic [2:0] DIG_GAP_HI = 3'd4;
  localparam logic [2:0] DIG_GAP_LO = 3'd3;
  localparam logic [2:0] DIG_R_HUN  = 3'd2;
  localparam logic [2:0] DIG_R_TEN  = 3'd1;
  localparam logic [2:0] DIG_R_ONE  = 3'd0;

  // Non-decimal codes fall through to a blank digit
  function automatic seg_t bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_dec.sv
// Combinational BCD to seven-segment decoder with a blank override.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  input  logic blank,
  output seg_t seg
);

  // Blank wins over the decoded pattern
  assign seg = blank ? SEG_BLANK : bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode scan driver for two 3-digit BCD values.
// Inputs are shadowed at frame boundaries so the display never tears.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
// of each 3-digit group (ones digit always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hundreds_l,
  input  logic [3:0] tens_l,
  input  logic [3:0] ones_l,
  input  logic [3:0] hundreds_r,
  input  logic [3:0] tens_r,
  input  logic [3:0] ones_r,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int                CNT_W     = $clog2(DIGIT_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_TICKS);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             slot_end;
  logic             frame_end;

  bcd_t sh_hun_l, sh_ten_l, sh_one_l;
  bcd_t sh_hun_r, sh_ten_r, sh_one_r;

  bcd_t sel_digit;
  logic sel_blank;
  seg_t dec_seg;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == DIG_L_HUN);
  assign dp        = 1'b1;

  // Slot prescaler and digit index; idx wraps naturally from 7 to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers only follow the inputs at the end of a full frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_hun_l <= '0;
      sh_ten_l <= '0;
      sh_one_l <= '0;
      sh_hun_r <= '0;
      sh_ten_r <= '0;
      sh_one_r <= '0;
    end else if (frame_end) begin
      sh_hun_l <= hundreds_l;
      sh_ten_l <= tens_l;
      sh_one_l <= ones_l;
      sh_hun_r <= hundreds_r;
      sh_ten_r <= tens_r;
      sh_one_r <= ones_r;
    end
  end

  // Pick the shadow digit for the current slot; the gap slots stay blank
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b1;
    case (idx)
      DIG_L_HUN: begin
        sel_digit = sh_hun_l;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = (sh_hun_l == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      DIG_L_TEN: begin
        sel_digit = sh_ten_l;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = (sh_hun_l == 4'd0) && (sh_ten_l == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      DIG_L_ONE: begin
        sel_digit = sh_one_l;
        sel_blank = 1'b0;
      end
      DIG_R_HUN: begin
        sel_digit = sh_hun_r;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = (sh_hun_r == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      DIG_R_TEN: begin
        sel_digit = sh_ten_r;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = (sh_hun_r == 4'd0) && (sh_ten_r == 4'd0);
`else
        sel_blank = 1'b0;
`endif
      end
      DIG_R_ONE: begin
        sel_digit = sh_one_r;
        sel_blank = 1'b0;
      end
      default: begin
        sel_digit = '0;
        sel_blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (sel_digit),
    .blank (sel_blank),
    .seg   (dec_seg)
  );

  // Registered display outputs; the slot opens with all anodes dark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (cnt < BLANK_END) begin
        an  <= 8'hFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(8'h01 << idx);
        seg <= dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with short slots (8 ticks, 2 blank).
// Honours SEG7_LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seg7_scan_driver;

  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int FRAME = DT * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hundreds_l = '0, tens_l = '0, ones_l = '0;
  logic [3:0] hundreds_r = '0, tens_r = '0, ones_r = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [6:0] seg_table [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  logic [3:0] sh [8];
  int         next_p;
  int         out_pos;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_ft;

  seg7_scan_driver #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hundreds_l (hundreds_l),
    .tens_l     (tens_l),
    .ones_l     (ones_l),
    .hundreds_r (hundreds_r),
    .tens_r     (tens_r),
    .ones_r     (ones_r),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected anodes for display position p (cycles since reset release)
  function automatic logic [7:0] model_an(input int p);
    int c = p % DT;
    int i = (p / DT) % 8;
    if (c < BT) return 8'hFF;
    return ~(8'h01 << i);
  endfunction

  // Expected cathodes for display position p from the captured digits
  function automatic logic [6:0] model_seg(input int p);
    int c = p % DT;
    int i = (p / DT) % 8;
    if (c < BT || i == 3 || i == 4) return 7'h7F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ((i == 7 || i == 2) && sh[i] == 4'd0) return 7'h7F;
    if ((i == 6 || i == 1) && sh[i+1] == 4'd0 && sh[i] == 4'd0) return 7'h7F;
`endif
    return seg_table[sh[i]];
  endfunction

  // Reference model: position counter plus frame-captured digit array
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      next_p  <= 0;
      out_pos <= -1;
      exp_an  <= 8'hFF;
      exp_seg <= 7'h7F;
      exp_ft  <= 1'b0;
      for (int k = 0; k < 8; k++) sh[k] <= 4'd0;
    end else begin
      exp_an  <= model_an(next_p);
      exp_seg <= model_seg(next_p);
      exp_ft  <= ((next_p % FRAME) == FRAME - 1);
      if ((next_p % FRAME) == FRAME - 1) begin
        sh[7] <= hundreds_l;
        sh[6] <= tens_l;
        sh[5] <= ones_l;
        sh[2] <= hundreds_r;
        sh[1] <= tens_r;
        sh[0] <= ones_r;
      end
      next_p  <= next_p + 1;
      out_pos <= next_p;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] hl, input logic [3:0] tl, input logic [3:0] ol,
                               input logic [3:0] hr, input logic [3:0] tr, input logic [3:0] o_r);
    hundreds_l = hl;
    tens_l     = tl;
    ones_l     = ol;
    hundreds_r = hr;
    tens_r     = tr;
    ones_r     = o_r;
  endtask

  // Wait until the outputs show slot idx at tick cnt
  task automatic waitOutput(input int i, input int c);
    for (int n = 0; n < 4 * FRAME; n++) begin
      @(negedge clk);
      if (out_pos >= 0 && (out_pos / DT) % 8 == i && out_pos % DT == c) return;
    end
    checkOutput("wait_output_timeout", 8'd0, 8'd1);
  endtask

  task automatic waitFrameTick();
    for (int n = 0; n < 4 * FRAME; n++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) return;
    end
    checkOutput("frame_tick_timeout", 8'd0, 8'd1);
  endtask

  // Continuous comparison against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_an", an, exp_an);
      checkOutput("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      checkOutput("model_dp", {7'b0, dp}, 8'd1);
      checkOutput("model_frame_tick", {7'b0, frame_tick}, {7'b0, exp_ft});
      checkOutput("one_anode_max", {7'b0, ($countones(~an) <= 1)}, 8'd1);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_seg", {1'b0, seg}, 8'h7F);
    checkOutput("reset_dp", {7'b0, dp}, 8'd1);
    checkOutput("reset_frame_tick", {7'b0, frame_tick}, 8'd0);

    rst = 1'b0;
    applyStimulus(4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3);
    repeat (2) @(negedge clk);
    checkOutput("release_blank_an", an, 8'hFF);
    @(negedge clk);
    checkOutput("release_first_an", an, 8'hFE);
    checkOutput("first_frame_zero", {1'b0, seg}, 8'h40);

    waitFrameTick();
    waitOutput(0, 2);
    checkOutput("r_one_an", an, 8'hFE);
    checkOutput("r_one_seg", {1'b0, seg}, {1'b0, 7'b0110000});
    waitOutput(3, 2);
    checkOutput("gap3_an", an, 8'hF7);
    checkOutput("gap3_seg", {1'b0, seg}, 8'h7F);
    waitOutput(4, 5);
    checkOutput("gap4_an", an, 8'hEF);
    checkOutput("gap4_seg", {1'b0, seg}, 8'h7F);
    waitOutput(5, 2);
    checkOutput("l_one_seg", {1'b0, seg}, {1'b0, 7'b0000010});
    waitOutput(7, 2);
    checkOutput("l_hun_an", an, 8'h7F);
    checkOutput("l_hun_seg", {1'b0, seg}, {1'b0, 7'b0011001});

    waitOutput(2, 3);
    applyStimulus(4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd8);
    waitOutput(0, 2);
    checkOutput("r_one_new_seg", {1'b0, seg}, {1'b0, 7'b0000000});

    applyStimulus(4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'hC);
    waitFrameTick();
    waitOutput(0, 3);
    checkOutput("code_c_an", an, 8'hFE);
    checkOutput("code_c_seg", {1'b0, seg}, 8'h7F);

    applyStimulus(4'd0, 4'd0, 4'd7, 4'd1, 4'd2, 4'd3);
    waitFrameTick();
    waitOutput(7, 2);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkOutput("lz_007_hun", {1'b0, seg}, 8'h7F);
`else
    checkOutput("lz_007_hun", {1'b0, seg}, 8'h40);
`endif
    waitOutput(6, 2);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkOutput("lz_007_ten", {1'b0, seg}, 8'h7F);
`else
    checkOutput("lz_007_ten", {1'b0, seg}, 8'h40);
`endif
    waitOutput(5, 2);
    checkOutput("lz_007_one", {1'b0, seg}, {1'b0, 7'b1111000});

    applyStimulus(4'd0, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3);
    waitFrameTick();
    waitOutput(6, 2);
    checkOutput("lz_050_ten", {1'b0, seg}, {1'b0, 7'b0010010});
    waitOutput(5, 2);
    checkOutput("lz_050_one", {1'b0, seg}, 8'h40);
    waitOutput(7, 2);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkOutput("lz_050_hun", {1'b0, seg}, 8'h7F);
`else
    checkOutput("lz_050_hun", {1'b0, seg}, 8'h40);
`endif

    waitFrameTick();
    begin
      int gap;
      gap = 0;
      for (int n = 0; n < 4 * FRAME; n++) begin
        @(negedge clk);
        gap++;
        if (frame_tick === 1'b1) break;
      end
      checkOutput("frame_tick_period", 8'(gap), 8'd64);
    end

    waitOutput(5, 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_an", an, 8'hFF);
    checkOutput("midreset_seg", {1'b0, seg}, 8'h7F);
    checkOutput("midreset_dp", {7'b0, dp}, 8'd1);
    checkOutput("midreset_frame_tick", {7'b0, frame_tick}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("restart_blank_an", an, 8'hFF);
    @(negedge clk);
    checkOutput("restart_first_an", an, 8'hFE);
    checkOutput("restart_shadow_zero", {1'b0, seg}, 8'h40);

    waitFrameTick();
    waitOutput(1, 4);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
